dmem_arbiter: RTL and testbench

Two-requester arbiter in front of the single-port data memory (DMEM). It shares the memory between the CPU MEM-stage load/store port and a debug/loader port used by benches and boot code to preload or inspect DMEM. The CPU has fixed priority, with a bounded-starvation guarantee for the debug port and an optional debug lock for bursts. It sits between U_CPU and U_DM inside Top.

---
 rtl/dmem_arbiter_if.sv | 24 ++
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one DMEM requester port (CPU or debug/loader).
// The requester holds req until gnt; reads return on rvalid/rdata one cycle after gnt.
interface dmem_arbiter_if #(
    parameter int AW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          gnt;
    logic          rvalid;
    logic [31:0]   rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Fixed-priority CPU/debug arbiter for the single-port DMEM, with starvation bound and debug lock.
// Optional grant/stall counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave cpu,
    dmem_arbiter_if.slave dbg,
    input  logic          dbg_lock,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic [31:0]   mem_rdata,
    output logic          cpu_stall
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]   stat_cpu_grants,
    output logic [31:0]   stat_dbg_grants,
    output logic [31:0]   stat_cpu_stall_cycles
`endif
);

    typedef enum logic {
        IDLE       = 1'b0,
        DBG_LOCKED = 1'b1
    } state_t;

    localparam logic       OWN_CPU    = 1'b0;
    localparam logic       OWN_DBG    = 1'b1;
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        rd_pend_q, rd_pend_d;
    logic        owner_q, owner_d;
    logic [31:0] cpu_rhold_q, cpu_rhold_d;
    logic [31:0] dbg_rhold_q, dbg_rhold_d;

    logic cpu_gnt;
    logic dbg_gnt;
    logic cpu_rvalid;
    logic dbg_rvalid;

    // A held lock overrides priority; once the lock drops, normal arbitration applies that cycle.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (state_q == DBG_LOCKED && dbg_lock) begin
            dbg_gnt = dbg.req;
        end else if (dbg.req && (!cpu.req || wait_cnt_q >= MAX_WAIT_C)) begin
            dbg_gnt = 1'b1;
        end else begin
            cpu_gnt = cpu.req;
        end
    end

    always_comb begin
        mem_en    = cpu_gnt | dbg_gnt;
        mem_we    = dbg_gnt ? dbg.we    : (cpu_gnt & cpu.we);
        mem_addr  = dbg_gnt ? dbg.addr  : cpu.addr;
        mem_wdata = dbg_gnt ? dbg.wdata : cpu.wdata;
        mem_wstrb = dbg_gnt ? dbg.wstrb : cpu.wstrb;
    end

    // Read data is not re-registered: it is steered from DMEM in the response cycle and held after.
    assign cpu_rvalid = rd_pend_q && (owner_q == OWN_CPU);
    assign dbg_rvalid = rd_pend_q && (owner_q == OWN_DBG);
    assign cpu_stall  = cpu.req && !cpu_gnt;

    assign cpu.gnt    = cpu_gnt;
    assign cpu.rvalid = cpu_rvalid;
    assign cpu.rdata  = cpu_rvalid ? mem_rdata : cpu_rhold_q;
    assign dbg.gnt    = dbg_gnt;
    assign dbg.rvalid = dbg_rvalid;
    assign dbg.rdata  = dbg_rvalid ? mem_rdata : dbg_rhold_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (dbg_gnt && dbg_lock) state_d = DBG_LOCKED;
            DBG_LOCKED: if (!dbg_lock)           state_d = IDLE;
            default:                             state_d = IDLE;
        endcase

        wait_cnt_d = wait_cnt_q;
        if (!dbg.req || dbg_gnt) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != 4'hF) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        rd_pend_d = mem_en && !mem_we;
        owner_d   = owner_q;
        if (rd_pend_d) begin
            owner_d = dbg_gnt ? OWN_DBG : OWN_CPU;
        end

        cpu_rhold_d = cpu_rvalid ? mem_rdata : cpu_rhold_q;
        dbg_rhold_d = dbg_rvalid ? mem_rdata : dbg_rhold_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            rd_pend_q   <= 1'b0;
            owner_q     <= OWN_CPU;
            cpu_rhold_q <= 32'd0;
            dbg_rhold_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            rd_pend_q   <= rd_pend_d;
            owner_q     <= owner_d;
            cpu_rhold_q <= cpu_rhold_d;
            dbg_rhold_q <= dbg_rhold_d;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [2:0] stat_inc;
    assign stat_inc = {cpu_stall, dbg_gnt, cpu_gnt};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        logic [31:0] stat_q, stat_d;

        always_comb stat_d = stat_q + 32'(stat_inc[gi]);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) stat_q <= 32'd0;
            else        stat_q <= stat_d;
        end
    end

    assign stat_cpu_grants       = g_stat[0].stat_q;
    assign stat_dbg_grants       = g_stat[1].stat_q;
    assign stat_cpu_stall_cycles = g_stat[2].stat_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-strobed synchronous DMEM model.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        dbg_lock;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        cpu_stall;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_cpu_grants, stat_dbg_grants, stat_cpu_stall_cycles;
`endif

    int passed = 0;
    int total  = 0;

    dmem_arbiter_if #(.AW(8)) cpu_if ();
    dmem_arbiter_if #(.AW(8)) dbg_if ();

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .MAX_WAIT(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu      (cpu_if),
        .dbg      (dbg_if),
        .dbg_lock (dbg_lock),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .cpu_stall(cpu_stall)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_cpu_grants      (stat_cpu_grants),
        .stat_dbg_grants      (stat_dbg_grants),
        .stat_cpu_stall_cycles(stat_cpu_stall_cycles)
`endif
    );

    logic [31:0] dmem [256];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) dmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= dmem[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input bit ok);
        total++;
        if (ok) passed++;
        else $error("FAIL %s", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [7:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb);
        cpu_if.req   = req;
        cpu_if.we    = we;
        cpu_if.addr  = addr;
        cpu_if.wdata = wdata;
        cpu_if.wstrb = strb;
    endtask

    task automatic dbg_drive(input logic req, input logic we, input logic [7:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb);
        dbg_if.req   = req;
        dbg_if.we    = we;
        dbg_if.addr  = addr;
        dbg_if.wdata = wdata;
        dbg_if.wstrb = strb;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  pre_addr [4];
        logic [31:0] pre_data [4];
        logic [9:0]  cpu_pat;

        pre_addr = '{8'd5, 8'd1, 8'd2, 8'd9};
        pre_data = '{32'h12345678, 32'h11111111, 32'h22222222, 32'h00000000};
        cpu_pat  = 10'b0111101111;

        reset    = 1'b0;
        dbg_lock = 1'b0;
        cpu_drive(0, 0, 0, 0, 0);
        dbg_drive(0, 0, 0, 0, 0);
        repeat (2) tick();

        check("rst_cpu_rvalid", cpu_if.rvalid === 1'b0);
        check("rst_dbg_rvalid", dbg_if.rvalid === 1'b0);
        check("rst_cpu_rdata", cpu_if.rdata === 32'd0);
        check("rst_mem_en", mem_en === 1'b0);
        check("rst_wait_cnt", dut.wait_cnt_q === 4'd0);
        check("rst_state", dut.state_q === 1'b0);
`ifdef DMEM_ARB_STATS_EN
        check("rst_stat_cpu", stat_cpu_grants === 32'd0);
`endif
        reset = 1'b1;
        tick();

        for (int k = 0; k < 4; k++) begin
            dbg_drive(1, 1, pre_addr[k], pre_data[k], 4'hF);
            #1;
            check("preload_dbg_gnt", dbg_if.gnt === 1'b1);
            tick();
        end
        dbg_drive(0, 0, 0, 0, 0);

        cpu_drive(1, 0, 8'd5, 0, 0);
        #1;
        check("cpu_rd_gnt", cpu_if.gnt === 1'b1);
        check("cpu_rd_mem_addr", mem_addr === 8'd5);
        check("cpu_rd_stall", cpu_stall === 1'b0);
        tick();
        cpu_drive(0, 0, 0, 0, 0);
        check("cpu_rd_rvalid", cpu_if.rvalid === 1'b1);
        check("cpu_rd_rdata", cpu_if.rdata === 32'h12345678);
        check("cpu_rd_dbg_rvalid", dbg_if.rvalid === 1'b0);
        tick();
        check("cpu_rd_rvalid_drop", cpu_if.rvalid === 1'b0);
        check("cpu_rd_rdata_hold", cpu_if.rdata === 32'h12345678);

        cpu_drive(1, 0, 8'd1, 0, 0);
        #1;
        check("alt_cpu_gnt", cpu_if.gnt === 1'b1);
        tick();
        cpu_drive(0, 0, 0, 0, 0);
        dbg_drive(1, 0, 8'd2, 0, 0);
        #1;
        check("alt_dbg_gnt", dbg_if.gnt === 1'b1);
        check("alt_cpu_rvalid", cpu_if.rvalid === 1'b1);
        check("alt_cpu_rdata", cpu_if.rdata === 32'h11111111);
        check("alt_dbg_rvalid0", dbg_if.rvalid === 1'b0);
        tick();
        dbg_drive(0, 0, 0, 0, 0);
        check("alt_dbg_rvalid", dbg_if.rvalid === 1'b1);
        check("alt_dbg_rdata", dbg_if.rdata === 32'h22222222);
        check("alt_cpu_rvalid0", cpu_if.rvalid === 1'b0);
        check("alt_cpu_rdata_hold", cpu_if.rdata === 32'h11111111);
        tick();

        cpu_drive(1, 0, 8'd1, 0, 0);
        dbg_drive(1, 0, 8'd2, 0, 0);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("starve_cpu_gnt", cpu_if.gnt === cpu_pat[i]);
            check("starve_dbg_gnt", dbg_if.gnt === !cpu_pat[i]);
            check("starve_cpu_stall", cpu_stall === !cpu_pat[i]);
            tick();
        end
        cpu_drive(0, 0, 0, 0, 0);
        dbg_drive(0, 0, 0, 0, 0);
        tick();

        dbg_lock = 1'b1;
        dbg_drive(1, 0, 8'd0, 0, 0);
        #1;
        check("lock_acq_gnt", dbg_if.gnt === 1'b1);
        tick();
        check("lock_state", dut.state_q === 1'b1);
        for (int k = 0; k < 4; k++) begin
            cpu_drive(1, 0, 8'd1, 0, 0);
            dbg_drive(1, 1, 8'(k), 32'h000000A0 + 32'(k), 4'hF);
            #1;
            check("lock_cpu_gnt", cpu_if.gnt === 1'b0);
            check("lock_cpu_stall", cpu_stall === 1'b1);
            check("lock_dbg_gnt", dbg_if.gnt === 1'b1);
            tick();
        end
        dbg_lock = 1'b0;
        dbg_drive(0, 0, 0, 0, 0);
        #1;
        check("unlock_cpu_gnt", cpu_if.gnt === 1'b1);
        tick();
        cpu_drive(0, 0, 0, 0, 0);
        check("unlock_state", dut.state_q === 1'b0);
        for (int k = 0; k < 4; k++) begin
            dbg_drive(1, 0, 8'(k), 0, 0);
            tick();
            check("lock_rb_rvalid", dbg_if.rvalid === 1'b1);
            check("lock_rb_rdata", dbg_if.rdata === (32'h000000A0 + 32'(k)));
        end
        dbg_drive(0, 0, 0, 0, 0);
        tick();

        dbg_lock = 1'b1;
        cpu_drive(1, 0, 8'd1, 0, 0);
        #1;
        check("nolock_cpu_gnt", cpu_if.gnt === 1'b1);
        tick();
        check("nolock_state", dut.state_q === 1'b0);
        dbg_lock = 1'b0;

        cpu_drive(1, 1, 8'd9, 32'h0000AB00, 4'b0010);
        #1;
        check("strb_cpu_gnt", cpu_if.gnt === 1'b1);
        check("strb_mem_we", mem_we === 1'b1);
        check("strb_mem_wstrb", mem_wstrb === 4'b0010);
        tick();
        cpu_drive(1, 0, 8'd9, 0, 0);
        check("strb_no_rvalid", cpu_if.rvalid === 1'b0);
        tick();
        cpu_drive(0, 0, 0, 0, 0);
        check("strb_rd_rvalid", cpu_if.rvalid === 1'b1);
        check("strb_rd_rdata", cpu_if.rdata === 32'h0000AB00);
        tick();

        cpu_drive(1, 0, 8'd5, 0, 0);
        dbg_drive(1, 0, 8'd2, 0, 0);
        tick();
        tick();
        check("arst_pre_rvalid", cpu_if.rvalid === 1'b1);
        check("arst_pre_wait", dut.wait_cnt_q === 4'd2);
        reset = 1'b0;
        #1;
        check("arst_cpu_rvalid", cpu_if.rvalid === 1'b0);
        check("arst_wait_cnt", dut.wait_cnt_q === 4'd0);
        check("arst_state", dut.state_q === 1'b0);
        check("arst_cpu_rdata", cpu_if.rdata === 32'd0);
`ifdef DMEM_ARB_STATS_EN
        check("arst_stat_cpu", stat_cpu_grants === 32'd0);
        check("arst_stat_dbg", stat_dbg_grants === 32'd0);
        check("arst_stat_stall", stat_cpu_stall_cycles === 32'd0);
`endif
        cpu_drive(0, 0, 0, 0, 0);
        dbg_drive(0, 0, 0, 0, 0);
        tick();
        check("arst_hold_rvalid", cpu_if.rvalid === 1'b0);
        reset = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
